// File: rtl/hazard_ctrl_md.sv
// hazard_ctrl_md: forwarding selects, D-stage stall and mult/div occupancy tracking for a 5-stage MIPS pipeline
module hazard_ctrl_md #(
    parameter int RA_W        = 5,
    parameter int T_W         = 3,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [RA_W-1:0]  a1_d,
    input  logic [RA_W-1:0]  a2_d,
    input  logic [RA_W-1:0]  a1_e,
    input  logic [RA_W-1:0]  a2_e,
    input  logic [RA_W-1:0]  a2_m,
    input  logic [RA_W-1:0]  a3_e,
    input  logic [RA_W-1:0]  a3_m,
    input  logic [RA_W-1:0]  a3_w,
    input  logic             we_e,
    input  logic             we_m,
    input  logic             we_w,
    input  logic [T_W-1:0]   tuse_rs,
    input  logic [T_W-1:0]   tuse_rt,
    input  logic [T_W-1:0]   tnew_e,
    input  logic [T_W-1:0]   tnew_m,
    input  logic             md_start_e,
    input  logic             md_is_div_e,
    input  logic             md_use_d,
    input  logic             stat_clr,
    output logic [1:0]       fw_cmp_rs,
    output logic [1:0]       fw_cmp_rt,
    output logic [1:0]       fw_alu_rs,
    output logic [1:0]       fw_alu_rt,
    output logic             fw_dm_rt,
    output logic             stall,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int MD_W = $clog2(DIV_CYCLES + 1);

    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic             reg_stall, md_stall;

    // M result is newer than W, so it wins when both match
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] a, input logic [RA_W-1:0] am,
                                           input logic wm, input logic [RA_W-1:0] aw, input logic ww);
        return (a != '0 && wm && a == am) ? 2'd2 : (a != '0 && ww && a == aw) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic hazard(input logic [RA_W-1:0] a, input logic [T_W-1:0] tuse,
                                    input logic [RA_W-1:0] ap, input logic wp, input logic [T_W-1:0] tnew);
        return a != '0 && wp && a == ap && tuse < tnew;
    endfunction

    always_comb begin
        fw_cmp_rs = fwd_sel(a1_d, a3_m, we_m, a3_w, we_w);
        fw_cmp_rt = fwd_sel(a2_d, a3_m, we_m, a3_w, we_w);
        fw_alu_rs = fwd_sel(a1_e, a3_m, we_m, a3_w, we_w);
        fw_alu_rt = fwd_sel(a2_e, a3_m, we_m, a3_w, we_w);
        fw_dm_rt  = a2_m != '0 && we_w && a2_m == a3_w;
        reg_stall = hazard(a1_d, tuse_rs, a3_e, we_e, tnew_e) | hazard(a1_d, tuse_rs, a3_m, we_m, tnew_m)
                  | hazard(a2_d, tuse_rt, a3_e, we_e, tnew_e) | hazard(a2_d, tuse_rt, a3_m, we_m, tnew_m);
        md_busy   = md_cnt_q != '0;
        md_stall  = md_use_d & (md_busy | md_start_e);
        stall     = reg_stall | md_stall;
        // a new start restarts the count rather than extending it
        md_cnt_d  = md_start_e ? (md_is_div_e ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES))
                  : md_busy ? md_cnt_q - 1'b1 : md_cnt_q;
        stall_cycles_d = stat_clr ? '0 : (stall && !(&stall_cycles_q)) ? stall_cycles_q + 1'b1 : stall_cycles_q;
        stall_cycles   = stall_cycles_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt_q       <= '0;
            stall_cycles_q <= '0;
        end else begin
            md_cnt_q       <= md_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_md.sv
// tb_hazard_ctrl_md: directed scoreboard bench; expectations are queued as stimulus is applied and popped at sample points
module tb_hazard_ctrl_md;
    localparam int CNT_W = 4;

    logic clk = 0, reset_n = 0;
    logic [4:0] a1_d = 0, a2_d = 0, a1_e = 0, a2_e = 0, a2_m = 0, a3_e = 0, a3_m = 0, a3_w = 0;
    logic we_e = 0, we_m = 0, we_w = 0;
    logic [2:0] tuse_rs = 0, tuse_rt = 0, tnew_e = 0, tnew_m = 0;
    logic md_start_e = 0, md_is_div_e = 0, md_use_d = 0, stat_clr = 0;
    logic [1:0] fw_cmp_rs, fw_cmp_rt, fw_alu_rs, fw_alu_rt;
    logic fw_dm_rt, stall, md_busy;
    logic [CNT_W-1:0] stall_cycles;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0;

    hazard_ctrl_md #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .a1_d(a1_d), .a2_d(a2_d), .a1_e(a1_e), .a2_e(a2_e), .a2_m(a2_m),
        .a3_e(a3_e), .a3_m(a3_m), .a3_w(a3_w), .we_e(we_e), .we_m(we_m), .we_w(we_w),
        .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .tnew_e(tnew_e), .tnew_m(tnew_m),
        .md_start_e(md_start_e), .md_is_div_e(md_is_div_e), .md_use_d(md_use_d), .stat_clr(stat_clr),
        .fw_cmp_rs(fw_cmp_rs), .fw_cmp_rt(fw_cmp_rt), .fw_alu_rs(fw_alu_rs), .fw_alu_rt(fw_alu_rt),
        .fw_dm_rt(fw_dm_rt), .stall(stall), .md_busy(md_busy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {a1_d, a2_d, a1_e, a2_e, a2_m, a3_e, a3_m, a3_w} = '0;
        {we_e, we_m, we_w, md_start_e, md_is_div_e, md_use_d} = '0;
        {tuse_rs, tuse_rt, tnew_e, tnew_m} = '0;
    endtask

    task automatic clear_stats();
        idle();
        stat_clr = 1;
        tick();
        stat_clr = 0;
    endtask

    initial begin
        // reset state
        #2;
        push("rst_busy", 0); push("rst_cnt", 0); push("rst_stall", 0);
        chk(32'(md_busy)); chk(32'(stall_cycles)); chk(32'(stall));
        #4 reset_n = 1;
        tick();

        // forwarding priority and zero register
        a1_e = 8; a3_m = 8; we_m = 1; a3_w = 8; we_w = 1;
        push("alu_rs_m", 2); #1 chk(32'(fw_alu_rs));
        we_m = 0;
        push("alu_rs_w", 1); #1 chk(32'(fw_alu_rs));
        a1_e = 0; a3_m = 0; a3_w = 0; we_m = 1;
        push("alu_rs_zero", 0); #1 chk(32'(fw_alu_rs));
        a2_e = 9; a3_m = 9; a3_w = 9;
        push("alu_rt_m", 2); #1 chk(32'(fw_alu_rt));
        a2_d = 3; a3_m = 4; a3_w = 3;
        push("cmp_rt_w", 1); push("cmp_rs_none", 0);
        #1 chk(32'(fw_cmp_rt)); chk(32'(fw_cmp_rs));
        a1_d = 4;
        push("cmp_rs_m", 2); #1 chk(32'(fw_cmp_rs));
        a2_m = 3;
        push("dm_rt_w", 1); #1 chk(32'(fw_dm_rt));
        we_w = 0;
        push("dm_rt_off", 0); #1 chk(32'(fw_dm_rt));
        idle();

        // load-use register stall
        a1_d = 5; tuse_rs = 0; a3_e = 5; we_e = 1; tnew_e = 2;
        push("lu_stall", 1); #1 chk(32'(stall));
        tuse_rs = 2;
        push("lu_tuse_eq", 0); #1 chk(32'(stall));
        tuse_rs = 0; a1_d = 0;
        push("lu_zero_reg", 0); #1 chk(32'(stall));
        idle();
        a2_d = 6; a3_m = 6; we_m = 1; tnew_m = 1; tuse_rt = 0;
        push("rt_m_stall", 1); #1 chk(32'(stall));
        clear_stats();
        push("clr_cnt", 0); #1 chk(32'(stall_cycles));

        // divide occupancy with md_use_d held
        tick();
        md_start_e = 1; md_is_div_e = 1; md_use_d = 1;
        for (int c = 0; c <= 11; c++) begin
            push($sformatf("div_stall_c%0d", c), (c <= 10) ? 1 : 0);
            push($sformatf("div_busy_c%0d", c), (c >= 1 && c <= 10) ? 1 : 0);
        end
        push("div_stat", 11);
        for (int c = 0; c <= 11; c++) begin
            #2;
            chk(32'(stall)); chk(32'(md_busy));
            if (c < 11) tick();
            if (c == 0) begin md_start_e = 0; md_is_div_e = 0; end
        end
        chk(32'(stall_cycles));

        // multiply then divide restart
        idle();
        tick();
        for (int c = 0; c <= 13; c++) push($sformatf("restart_busy_c%0d", c), (c >= 1 && c <= 12) ? 1 : 0);
        for (int c = 0; c <= 13; c++) begin
            md_start_e = (c == 0 || c == 2);
            md_is_div_e = (c == 2);
            #2 chk(32'(md_busy));
            tick();
        end
        clear_stats();

        // asynchronous reset during a divide
        md_start_e = 1; md_is_div_e = 1; md_use_d = 1;
        tick();
        md_start_e = 0; md_is_div_e = 0;
        tick(); tick(); tick();
        push("ar_busy_pre", 1); push("ar_stat_pre", 4);
        #1 chk(32'(md_busy)); chk(32'(stall_cycles));
        reset_n = 0;
        push("ar_busy", 0); push("ar_stat", 0);
        #1 chk(32'(md_busy)); chk(32'(stall_cycles));
        #1 reset_n = 1;
        push("ar_post_stall", 0); #1 chk(32'(stall));
        tick();
        push("ar_post_busy", 0); chk(32'(md_busy));
        clear_stats();

        // saturation and clear priority
        a1_d = 5; tuse_rs = 0; a3_e = 5; we_e = 1; tnew_e = 2;
        repeat (20) tick();
        push("sat", 15); chk(32'(stall_cycles));
        stat_clr = 1;
        tick();
        push("clr_wins", 0); chk(32'(stall_cycles));
        stat_clr = 0;
        tick();
        push("after_clr", 1); chk(32'(stall_cycles));

        if (sb.size() != 0) begin
            checks++; errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
